shuffle_sequencer: RTL
======================

Name: shuffle_sequencer

Overview:
- Owns the SIMD 16-bit-lane shuffle unit and runs a short program of up to MAX_PASS shuffle control words against one operand pair.
- The result of pass k becomes the rs1 operand of pass k+1. rs2 stays constant for the whole program.
- Sits in the execute stage between issue (valid/ready request) and writeback (valid/ready response).
- It is the only writer of the shuffle unit's control register.

Parameters:
- SIMD_W, 64, operand/result width; four 16-bit lanes.
- DATA_W, 32, width of the shuffle unit's control input.
- CTL_W, 12, used bits per control word: four 3-bit lane selects; sel[2] picks rs2, sel[1:0] picks the lane.
- MAX_PASS, 4, maximum program length.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_rs1  in  SIMD_W  initial rs1 operand
- req_rs2  in  SIMD_W  rs2 operand, held for all passes
- req_prog  in  MAX_PASS*CTL_W  control words; word k in bits [k*CTL_W +: CTL_W]
- req_npass  in  2  pass count minus 1 (0 means 1 pass, 3 means 4 passes)
- flush  in  1  abort any in-flight program
- su_rs1  out  SIMD_W  to shuffle unit rs1
- su_rs2  out  SIMD_W  to shuffle unit rs2
- su_ctl  out  DATA_W  to shuffle unit control; upper DATA_W-CTL_W bits are zero
- su_ctl_en  out  1  shuffle unit control-register load enable
- su_result  in  SIMD_W  shuffle unit combinational result (uses its registered control)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts
- rsp_data  out  SIMD_W  final result
- busy  out  1  state is not IDLE

Behaviour:
- Shuffle unit timing contract: a control word presented with su_ctl_en in cycle T is applied to su_rs1/su_rs2 in cycle T+1.
- States:
  - IDLE: req_ready=1. On req_valid, capture wrk1<=req_rs1, wrk2<=req_rs2, prog, last<=req_npass, idx<=0, then go to CFG.
  - CFG: su_ctl_en=1, su_ctl=prog[0]; go to RUN.
  - RUN: wrk1<=su_result (pass idx).
    - If idx!=last: su_ctl_en=1, su_ctl=prog[idx+1], idx<=idx+1, stay in RUN.
    - If idx==last: su_ctl_en=0; go to DONE.
  - DONE: rsp_valid=1, rsp_data=wrk1. On rsp_ready go to IDLE. Back-to-back requests are not accepted in DONE.
- su_rs1=wrk1 and su_rs2=wrk2 at all times.
- Latency: handshake in cycle 0, CFG in cycle 1, RUN in cycles 2..npass+2, rsp_valid from cycle npass+3.
  - Throughput is one pass per cycle after CFG.
- su_ctl_en is asserted only in CFG and in non-final RUN cycles. It is never asserted in IDLE or DONE. The shuffle unit control register therefore holds the last applied word while the sequencer is idle.
- rsp_valid and rsp_data stay stable until rsp_ready.
- flush:
  - Highest priority: next state is IDLE from any state, a DONE response is dropped, and no su_ctl_en is issued in that cycle.
  - flush in IDLE together with req_valid: the request is not accepted; req_ready=0 while flush=1.
- Reset (asynchronous, also mid-program):
  - State IDLE, idx=0, last=0, wrk1=wrk2=0, prog=0.
  - Outputs: req_ready=1, rsp_valid=0, rsp_data=0, su_ctl_en=0, su_ctl=0, busy=0.
- Unused prog words (index > last) are ignored. idx never exceeds last.

Optional Feature:
- Macro SHUFFLE_SEQ_FAST_EN.
- Defined:
  - The CFG state is removed. In the IDLE accept cycle, su_ctl_en=1 and su_ctl=req_prog[0], and the FSM moves straight to RUN.
  - Same-cycle bypass: su_rs1/su_rs2 show the request operands in the accept cycle only.
  - rsp_valid comes from cycle npass+2.
- Undefined: behaviour exactly as described in Behaviour.

Decomposition:
- Shared package (shuffle_pkg):
  - State enum: IDLE, CFG, RUN, DONE.
  - Constants SIMD_W, CTL_W, MAX_PASS, LANE_W=16, SEL_W=3.
  - Typedef for a lane-select record and for a control word.
  - Identity control constant 12'h688.
- Sub-module: none required. The FSM plus operand registers is natural as one module. The existing shuffle unit is instantiated only in the bench and at the top level.

Test Plan:
Operands: rs1=0x4444_3333_2222_1111, rs2=0x8888_7777_6666_5555.
- npass=0, prog[0]=0x053: rsp_data=0x1111_2222_3333_4444; rsp_valid first seen 3 cycles after accept; su_ctl_en high exactly 1 cycle.
- npass=1, prog[0]=prog[1]=0x053: rsp_data=0x4444_3333_2222_1111 (double reverse); su_ctl_en high 2 consecutive cycles.
- npass=3, prog[0]=0xFFF, then three words of 0x688: rsp_data=0x8888_8888_8888_8888; rs2 stays unchanged on su_rs2 throughout.
- rsp_ready held low 5 cycles in DONE: rsp_valid and rsp_data stable, req_ready=0, a new req_valid is not accepted; it is accepted the cycle after return to IDLE.
- flush in the second RUN cycle of a 4-pass program: next cycle IDLE, rsp_valid never asserts, next request completes correctly. Async rst_n mid-RUN: all outputs reach reset values immediately.
- Build with SHUFFLE_SEQ_FAST_EN, npass=0, prog[0]=0x053: same data as the first scenario, rsp_valid one cycle earlier; su_ctl_en asserted in the accept cycle.

Source files
------------

// File: rtl/shuffle_pkg.sv
// Shared types and constants for the shuffle sequencer.
// SHUFFLE_SEQ_FAST_EN (see shuffle_sequencer.sv) removes the CFG cycle; nothing here changes with it.
package shuffle_pkg;
  localparam int SIMD_W   = 64;
  localparam int DATA_W   = 32;
  localparam int CTL_W    = 12;
  localparam int MAX_PASS = 4;
  localparam int LANE_W   = 16;
  localparam int SEL_W    = 3;
  localparam int NLANE    = SIMD_W / LANE_W;

  typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} state_e;

  // sel[2] picks rs2, sel[1:0] picks the source lane
  typedef struct packed {
    logic             src;
    logic [SEL_W-2:0] lane;
  } lane_sel_t;

  typedef lane_sel_t [NLANE-1:0] ctl_word_t;

  localparam ctl_word_t CTL_IDENT = 12'h688;

  function automatic logic [DATA_W-1:0] ctl_zext(input ctl_word_t w);
    return {{(DATA_W-CTL_W){1'b0}}, w};
  endfunction
endpackage

// File: rtl/shuffle_sequencer_if.sv
// Issue/writeback handshake and shuffle-unit drive lines of the shuffle sequencer.
interface shuffle_sequencer_if;
  import shuffle_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic [SIMD_W-1:0]         req_rs1;
  logic [SIMD_W-1:0]         req_rs2;
  logic [MAX_PASS*CTL_W-1:0] req_prog;
  logic [1:0]                req_npass;
  logic                      flush;
  logic [SIMD_W-1:0]         su_rs1;
  logic [SIMD_W-1:0]         su_rs2;
  logic [DATA_W-1:0]         su_ctl;
  logic                      su_ctl_en;
  logic [SIMD_W-1:0]         su_result;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [SIMD_W-1:0]         rsp_data;
  logic                      busy;

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_prog, req_npass, flush, su_result, rsp_ready,
    output req_ready, su_rs1, su_rs2, su_ctl, su_ctl_en, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_prog, req_npass, flush, su_result, rsp_ready,
    input  req_ready, su_rs1, su_rs2, su_ctl, su_ctl_en, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/shuffle_sequencer.sv
// Runs up to MAX_PASS shuffle control words over one operand pair, feeding each result back as rs1.
// `define SHUFFLE_SEQ_FAST_EN to skip the CFG cycle (first control word loads in the accept cycle).
module shuffle_sequencer
  import shuffle_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  shuffle_sequencer_if.slave sq
);

  state_e                     state_q, state_d;
  logic      [1:0]            idx_q, idx_d;
  logic      [1:0]            last_q, last_d;
  logic      [SIMD_W-1:0]     wrk1_q, wrk1_d;
  logic      [SIMD_W-1:0]     wrk2_q, wrk2_d;
  ctl_word_t [MAX_PASS-1:0]   prog_q, prog_d;
  ctl_word_t                  ctl_w;
  logic                       ctl_en;
  logic                       accept;

  assign accept = (state_q == IDLE) && sq.req_valid && !sq.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      wrk1_q  <= '0;
      wrk2_q  <= '0;
      prog_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wrk1_q  <= wrk1_d;
      wrk2_q  <= wrk2_d;
      prog_q  <= prog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    wrk1_d  = wrk1_q;
    wrk2_d  = wrk2_q;
    prog_d  = prog_q;
    ctl_en  = 1'b0;
    ctl_w   = '0;
    case (state_q)
      IDLE: if (accept) begin
        wrk1_d = sq.req_rs1;
        wrk2_d = sq.req_rs2;
        prog_d = sq.req_prog;
        last_d = sq.req_npass;
        idx_d  = '0;
`ifdef SHUFFLE_SEQ_FAST_EN
        ctl_en  = 1'b1;
        ctl_w   = sq.req_prog[CTL_W-1:0];
        state_d = RUN;
`else
        state_d = CFG;
`endif
      end
      CFG: begin
        ctl_en  = 1'b1;
        ctl_w   = prog_q[0];
        state_d = RUN;
      end
      // su_result reflects word idx this cycle; preload word idx+1 for the next pass
      RUN: begin
        wrk1_d = sq.su_result;
        if (idx_q != last_q) begin
          ctl_en = 1'b1;
          ctl_w  = prog_q[idx_q + 2'd1];
          idx_d  = idx_q + 2'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: if (sq.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // flush wins over everything, including a pending control load
    if (sq.flush) begin
      state_d = IDLE;
      ctl_en  = 1'b0;
    end
  end

  assign sq.req_ready = (state_q == IDLE) && !sq.flush;
  assign sq.busy      = (state_q != IDLE);
  assign sq.rsp_valid = (state_q == DONE);
  assign sq.rsp_data  = (state_q == DONE) ? wrk1_q : '0;
  assign sq.su_ctl_en = ctl_en;
  assign sq.su_ctl    = ctl_zext(ctl_w);

`ifdef SHUFFLE_SEQ_FAST_EN
  // the unit computes off the request operands in the accept cycle
  assign sq.su_rs1 = accept ? sq.req_rs1 : wrk1_q;
  assign sq.su_rs2 = accept ? sq.req_rs2 : wrk2_q;
`else
  assign sq.su_rs1 = wrk1_q;
  assign sq.su_rs2 = wrk2_q;
`endif

endmodule
